// File: rtl/user_pkt_bridge.sv
// user_pkt_bridge: user-side TX load/stream and RX capture/hold buffers for the MAC user interface.
// Optional statistics counters are enabled with `define UIF_STATS_EN.
module user_pkt_bridge #(
   parameter  int TX_DEPTH = 64,
   parameter  int RX_DEPTH = 64,
   parameter  int CNT_W    = 16,
   localparam int TAW      = $clog2(TX_DEPTH),
   localparam int RAW      = $clog2(RX_DEPTH)
) (
   input  logic           clk_user,
   input  logic           reset_n,
   input  logic           cpu_init_end,
   input  logic           rx_mac_ra,
   output logic           rx_mac_rd,
   input  logic [31:0]    rx_mac_data,
   input  logic [1:0]     rx_mac_be,
   input  logic           rx_mac_pa,
   input  logic           rx_mac_sop,
   input  logic           rx_mac_eop,
   input  logic           tx_mac_wa,
   output logic           tx_mac_wr,
   output logic [31:0]    tx_mac_data,
   output logic [1:0]     tx_mac_be,
   output logic           tx_mac_sop,
   output logic           tx_mac_eop,
   input  logic           tx_ld_wr,
   input  logic [31:0]    tx_ld_data,
   input  logic [1:0]     tx_ld_be,
   input  logic           tx_ld_last,
   output logic           tx_ld_rdy,
   output logic           tx_done,
   output logic           rx_pkt_vld,
   output logic [RAW:0]   rx_pkt_words,
   output logic [1:0]     rx_pkt_be,
   output logic           rx_pkt_ovf,
   input  logic [RAW-1:0] rx_rd_addr,
   output logic [31:0]    rx_rd_data,
   input  logic           rx_pkt_ack
`ifdef UIF_STATS_EN
   ,
   output logic [CNT_W-1:0] tx_pkt_cnt,
   output logic [CNT_W-1:0] rx_pkt_cnt,
   output logic [CNT_W-1:0] rx_ovf_cnt
`endif
);
   typedef enum logic {TX_LOAD, TX_SEND} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_WORK, RX_HOLD} rx_state_e;
   logic [31:0]    tx_mem [TX_DEPTH];
   logic [31:0]    rx_mem [RX_DEPTH];
   tx_state_e      tx_state_q, tx_state_d;
   logic [TAW-1:0] tx_wptr_q, tx_wptr_d;
   logic [TAW-1:0] tx_rptr_q, tx_rptr_d;
   logic [TAW-1:0] tx_last_q, tx_last_d;
   logic [1:0]     tx_be_q, tx_be_d;
   logic           tx_done_q, tx_done_d;
   logic           tx_we;
   rx_state_e      rx_state_q, rx_state_d;
   logic [RAW:0]   rx_wptr_q, rx_wptr_d;
   logic [RAW:0]   rx_words_q, rx_words_d;
   logic [1:0]     rx_be_q, rx_be_d;
   logic           rx_ovf_q, rx_ovf_d;
   logic [31:0]    rx_rd_data_q, rx_rd_data_d;
   logic           rx_we;
   logic [RAW-1:0] rx_waddr;
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TX_LOAD;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_last_q  <= '0;
         tx_be_q    <= '0;
         tx_done_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_last_q  <= tx_last_d;
         tx_be_q    <= tx_be_d;
         tx_done_q  <= tx_done_d;
      end
   end
   always_ff @(posedge clk_user) begin
      if (tx_we) tx_mem[tx_wptr_q] <= tx_ld_data;
   end
   // The top buffer slot closes the packet even without tx_ld_last; the wrap also rewinds wptr.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      tx_last_d  = tx_last_q;
      tx_be_d    = tx_be_q;
      tx_done_d  = 1'b0;
      tx_we      = 1'b0;
      if (tx_state_q == TX_LOAD) begin
         if (tx_ld_wr) begin
            tx_we     = 1'b1;
            tx_wptr_d = tx_wptr_q + 1'b1;
            if (tx_ld_last || &tx_wptr_q) begin
               tx_last_d  = tx_wptr_q;
               tx_be_d    = tx_ld_last ? tx_ld_be : 2'd0;
               tx_state_d = TX_SEND;
            end
         end
      end else if (tx_mac_wr) begin
         tx_rptr_d = tx_rptr_q + 1'b1;
         if (tx_mac_eop) begin
            tx_rptr_d  = '0;
            tx_wptr_d  = '0;
            tx_done_d  = 1'b1;
            tx_state_d = TX_LOAD;
         end
      end
   end
   always_comb begin
      tx_ld_rdy   = tx_state_q == TX_LOAD;
      tx_mac_wr   = (tx_state_q == TX_SEND) & tx_mac_wa & cpu_init_end;
      tx_mac_data = (tx_state_q == TX_SEND) ? tx_mem[tx_rptr_q] : 32'd0;
      tx_mac_sop  = (tx_state_q == TX_SEND) & (tx_rptr_q == '0);
      tx_mac_eop  = (tx_state_q == TX_SEND) & (tx_rptr_q == tx_last_q);
      tx_mac_be   = tx_mac_eop ? tx_be_q : 2'd0;
      tx_done     = tx_done_q;
   end
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q   <= RX_IDLE;
         rx_wptr_q    <= '0;
         rx_words_q   <= '0;
         rx_be_q      <= '0;
         rx_ovf_q     <= 1'b0;
         rx_rd_data_q <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_wptr_q    <= rx_wptr_d;
         rx_words_q   <= rx_words_d;
         rx_be_q      <= rx_be_d;
         rx_ovf_q     <= rx_ovf_d;
         rx_rd_data_q <= rx_rd_data_d;
      end
   end
   always_ff @(posedge clk_user) begin
      if (rx_we) rx_mem[rx_waddr] <= rx_mac_data;
   end
   // wptr saturates at RX_DEPTH (MSB set); later words are dropped and flagged as overflow.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_wptr_d    = rx_wptr_q;
      rx_words_d   = rx_words_q;
      rx_be_d      = rx_be_q;
      rx_ovf_d     = rx_ovf_q;
      rx_rd_data_d = rx_mem[rx_rd_addr];
      rx_we        = 1'b0;
      rx_waddr     = '0;
      if (rx_state_q == RX_HOLD) begin
         if (rx_pkt_ack) rx_state_d = RX_IDLE;
      end else if (rx_mac_pa && (rx_mac_sop || rx_state_q == RX_WORK)) begin
         if (rx_mac_sop) begin
            rx_we     = 1'b1;
            rx_wptr_d = (RAW+1)'(1);
            rx_ovf_d  = 1'b0;
         end else if (!rx_wptr_q[RAW]) begin
            rx_we     = 1'b1;
            rx_waddr  = rx_wptr_q[RAW-1:0];
            rx_wptr_d = rx_wptr_q + 1'b1;
         end else begin
            rx_ovf_d = 1'b1;
         end
         rx_state_d = rx_mac_eop ? RX_HOLD : RX_WORK;
         if (rx_mac_eop) begin
            rx_words_d = rx_wptr_d;
            rx_be_d    = rx_mac_be;
         end
      end
   end
   always_comb begin
      rx_mac_rd    = rx_mac_ra & cpu_init_end & (rx_state_q != RX_HOLD) & ~(rx_mac_pa & rx_mac_eop);
      rx_pkt_vld   = rx_state_q == RX_HOLD;
      rx_pkt_words = rx_words_q;
      rx_pkt_be    = rx_be_q;
      rx_pkt_ovf   = rx_ovf_q;
      rx_rd_data   = rx_rd_data_q;
   end
`ifdef UIF_STATS_EN
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
   logic             rx_hold_entry;
   always_comb begin
      rx_hold_entry = (rx_state_q != RX_HOLD) && (rx_state_d == RX_HOLD);
      tx_cnt_d      = tx_cnt_q + CNT_W'(tx_done_q);
      rx_cnt_d      = rx_cnt_q + CNT_W'(rx_hold_entry);
      ovf_cnt_d     = ovf_cnt_q + CNT_W'(rx_hold_entry & rx_ovf_d);
   end
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         ovf_cnt_q <= '0;
      end else begin
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end
   always_comb begin
      tx_pkt_cnt = tx_cnt_q;
      rx_pkt_cnt = rx_cnt_q;
      rx_ovf_cnt = ovf_cnt_q;
   end
`else
`endif
endmodule

// File: tb/tb_user_pkt_bridge.sv
// tb_user_pkt_bridge: directed + randomized checks of user_pkt_bridge against a queue-based packet model.
module tb_user_pkt_bridge;
   localparam int TXD = 8;
   localparam int RXD = 4;
   localparam int RAW = $clog2(RXD);
   localparam int CW  = 16;
   logic           clk_user = 1'b0;
   logic           reset_n, cpu_init_end, rx_mac_ra, rx_mac_rd, rx_mac_pa, rx_mac_sop, rx_mac_eop;
   logic [31:0]    rx_mac_data, tx_mac_data, tx_ld_data, rx_rd_data;
   logic [1:0]     rx_mac_be, tx_mac_be, tx_ld_be, rx_pkt_be;
   logic           tx_mac_wa, tx_mac_wr, tx_mac_sop, tx_mac_eop;
   logic           tx_ld_wr, tx_ld_last, tx_ld_rdy, tx_done, rx_pkt_vld, rx_pkt_ovf, rx_pkt_ack;
   logic [RAW:0]   rx_pkt_words;
   logic [RAW-1:0] rx_rd_addr;
`ifdef UIF_STATS_EN
   logic [CW-1:0]  tx_pkt_cnt, rx_pkt_cnt, rx_ovf_cnt;
`endif
   always #5 clk_user = ~clk_user;
   user_pkt_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_W(CW)) dut (
      .clk_user(clk_user), .reset_n(reset_n), .cpu_init_end(cpu_init_end),
      .rx_mac_ra(rx_mac_ra), .rx_mac_rd(rx_mac_rd), .rx_mac_data(rx_mac_data), .rx_mac_be(rx_mac_be),
      .rx_mac_pa(rx_mac_pa), .rx_mac_sop(rx_mac_sop), .rx_mac_eop(rx_mac_eop),
      .tx_mac_wa(tx_mac_wa), .tx_mac_wr(tx_mac_wr), .tx_mac_data(tx_mac_data), .tx_mac_be(tx_mac_be),
      .tx_mac_sop(tx_mac_sop), .tx_mac_eop(tx_mac_eop),
      .tx_ld_wr(tx_ld_wr), .tx_ld_data(tx_ld_data), .tx_ld_be(tx_ld_be), .tx_ld_last(tx_ld_last),
      .tx_ld_rdy(tx_ld_rdy), .tx_done(tx_done),
      .rx_pkt_vld(rx_pkt_vld), .rx_pkt_words(rx_pkt_words), .rx_pkt_be(rx_pkt_be), .rx_pkt_ovf(rx_pkt_ovf),
      .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data), .rx_pkt_ack(rx_pkt_ack)
`ifdef UIF_STATS_EN
      , .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_ovf_cnt(rx_ovf_cnt)
`endif
   );
   int          checks = 0, errors = 0, done_cnt = 0;
   int          exp_tx_pkts = 0, exp_rx_pkts = 0, exp_rx_ovfs = 0;
   logic [35:0] tx_obs[$];
   logic [31:0] exp_tx[$];
   logic [31:0] rx_words[$];
   logic [1:0]  exp_tx_be, exp_rx_be;
   logic        exp_rx_ovf;
   // Monitor: a word counts as transferred when wr is high at the coming edge.
   always @(negedge clk_user) begin
      if (tx_mac_wr) tx_obs.push_back({tx_mac_sop, tx_mac_eop, tx_mac_be, tx_mac_data});
      if (tx_done) done_cnt++;
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk_user);
      #1;
   endtask
   task automatic tx_load(input int n, input logic [1:0] lbe, input bit fixed);
      logic [31:0] w;
      exp_tx.delete();
      for (int i = 0; i < n; i++) begin
         w          = fixed ? {8{4'(i + 1)}} : $urandom;
         tx_ld_wr   = 1'b1;
         tx_ld_data = w;
         tx_ld_last = (i == n - 1);
         tx_ld_be   = lbe;
         if (i < TXD) exp_tx.push_back(w);
         tick;
      end
      tx_ld_wr   = 1'b0;
      tx_ld_last = 1'b0;
      exp_tx_be  = (n <= TXD) ? lbe : 2'd0;
      check("tx_ld_rdy_busy", tx_ld_rdy, 0);
   endtask
   task automatic tx_send(input int mode, input string tag);
      int         k  = 0;
      int         d0 = done_cnt;
      logic [4:0] pat = 5'b11001;
      tx_obs.delete();
      while (done_cnt == d0 && k < 100) begin
         tx_mac_wa = (mode == 0) ? 1'b1 : (mode == 1) ? (k < 5 ? pat[k] : 1'b1) : 1'($urandom);
         @(negedge clk_user);
         if (!tx_mac_wa && tx_obs.size() < exp_tx.size())
            check({tag, "_hold"}, tx_mac_data, exp_tx[tx_obs.size()]);
         tick;
         k++;
      end
      tx_mac_wa = 1'b0;
      if (mode == 0) check({tag, "_cycles"}, k, exp_tx.size() + 1);
      repeat (3) tick;
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_nwr"}, tx_obs.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < tx_obs.size(); i++)
         check($sformatf("%s_w%0d", tag, i), tx_obs[i],
               {i == 0, i == exp_tx.size() - 1, (i == exp_tx.size() - 1) ? exp_tx_be : 2'd0, exp_tx[i]});
      check({tag, "_rdy"}, tx_ld_rdy, 1);
      exp_tx_pkts++;
   endtask
   task automatic rx_drive(input int n, input logic [1:0] lbe, input int rs, input string tag);
      logic [31:0] w;
      rx_words.delete();
      for (int i = 0; i < n; i++) begin
         w           = $urandom;
         rx_mac_pa   = 1'b1;
         rx_mac_data = w;
         rx_mac_sop  = (i == 0 || i == rs);
         rx_mac_eop  = (i == n - 1);
         rx_mac_be   = (i == n - 1) ? lbe : 2'd0;
         if (i >= rs && i - rs < RXD) rx_words.push_back(w);
         @(negedge clk_user);
         check($sformatf("%s_rd%0d", tag, i), rx_mac_rd, i != n - 1);
         tick;
      end
      rx_mac_pa   = 1'b0;
      rx_mac_sop  = 1'b0;
      rx_mac_eop  = 1'b0;
      exp_rx_be   = lbe;
      exp_rx_ovf  = (n - rs) > RXD;
      exp_rx_pkts++;
      if (exp_rx_ovf) exp_rx_ovfs++;
   endtask
   task automatic rx_verify(input string tag);
      @(negedge clk_user);
      check({tag, "_vld"}, rx_pkt_vld, 1);
      check({tag, "_words"}, rx_pkt_words, rx_words.size());
      check({tag, "_be"}, rx_pkt_be, exp_rx_be);
      check({tag, "_ovf"}, rx_pkt_ovf, exp_rx_ovf);
      for (int a = 0; a < rx_words.size(); a++) begin
         rx_rd_addr = RAW'(a);
         tick;
         @(negedge clk_user);
         check($sformatf("%s_data%0d", tag, a), rx_rd_data, rx_words[a]);
      end
      check({tag, "_rd_held"}, rx_mac_rd, 0);
      rx_pkt_ack = 1'b1;
      tick;
      rx_pkt_ack = 1'b0;
      @(negedge clk_user);
      check({tag, "_vld_clr"}, rx_pkt_vld, 0);
      check({tag, "_rd_resume"}, rx_mac_rd, 1);
   endtask
   initial begin
      reset_n = 1'b0; cpu_init_end = 1'b0; rx_mac_ra = 1'b1; rx_mac_pa = 1'b0; rx_mac_sop = 1'b0;
      rx_mac_eop = 1'b0; rx_mac_data = '0; rx_mac_be = '0; tx_mac_wa = 1'b0; tx_ld_wr = 1'b0;
      tx_ld_data = '0; tx_ld_be = '0; tx_ld_last = 1'b0; rx_rd_addr = '0; rx_pkt_ack = 1'b0;
      repeat (3) @(negedge clk_user);
      check("rst_tx_wr", tx_mac_wr, 0);
      check("rst_tx_data", tx_mac_data, 0);
      check("rst_tx_flags", {tx_mac_sop, tx_mac_eop, tx_mac_be, tx_done}, 0);
      check("rst_ld_rdy", tx_ld_rdy, 1);
      check("rst_rx_rd", rx_mac_rd, 0);
      check("rst_rx_pkt", {rx_pkt_vld, rx_pkt_words, rx_pkt_be, rx_pkt_ovf}, 0);
      check("rst_rx_data", rx_rd_data, 0);
      tick;
      reset_n = 1'b1;
      tick;
      tx_load(3, 2'd2, 1'b1);
      tx_mac_wa = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_user);
         check("noinit_wr", tx_mac_wr, 0);
         check("noinit_rd", rx_mac_rd, 0);
         tick;
      end
      cpu_init_end = 1'b1;
      rx_mac_ra    = 1'b0;
      tx_send(0, "tx_init");
      tx_load(4, 2'd1, 1'b0);
      tx_mac_wa = 1'b1;
      tick;
      tick;
      reset_n   = 1'b0;
      tx_mac_wa = 1'b0;
      exp_tx_pkts = 0; exp_rx_pkts = 0; exp_rx_ovfs = 0;
      @(negedge clk_user);
      check("midrst_wr", tx_mac_wr, 0);
      check("midrst_out", {tx_mac_sop, tx_mac_eop, tx_mac_be, tx_mac_data}, 0);
      check("midrst_rdy", tx_ld_rdy, 1);
      tick;
      reset_n = 1'b1;
      tick;
      tx_load(2, 2'd3, 1'b0);
      tx_send(0, "tx_after_rst");
      tx_load(3, 2'd2, 1'b1);
      tx_send(0, "tx_basic");
      tx_load(3, 2'd2, 1'b1);
      tx_send(1, "tx_wa_toggle");
      tx_load(TXD + 1, 2'd3, 1'b0);
      tx_send(2, "tx_forced_last");
      tx_load(1, 2'd1, 1'b0);
      tx_send(0, "tx_single");
      tx_load($urandom_range(2, TXD), 2'($urandom), 1'b0);
      tx_send(2, "tx_random");
      rx_mac_ra   = 1'b1;
      rx_mac_pa   = 1'b1;
      rx_mac_data = 32'hdead_beef;
      tick;
      rx_mac_pa = 1'b0;
      rx_drive(4, 2'd0, 0, "rx_four");
      rx_verify("rx_four");
      rx_drive(6, 2'd2, 0, "rx_ovf");
      rx_verify("rx_ovf");
      rx_drive(1, 2'd1, 0, "rx_single");
      rx_verify("rx_single");
      rx_drive(5, 2'd3, 3, "rx_restart");
      rx_verify("rx_restart");
      rx_drive($urandom_range(1, 7), 2'($urandom), 0, "rx_random");
      rx_verify("rx_random");
`ifdef UIF_STATS_EN
      check("stat_tx", tx_pkt_cnt, exp_tx_pkts);
      check("stat_rx", rx_pkt_cnt, exp_rx_pkts);
      check("stat_ovf", rx_ovf_cnt, exp_rx_ovfs);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/user_pkt_bridge.md
Name: user_pkt_bridge

Overview:
- Synthesizable, parametrised user-side packet bridge for the MAC user interface.
- Replaces the task-driven bench user interface.
- TX path: user loads a packet word-by-word into an internal buffer; an FSM streams it to the MAC with wa/wr handshake, sop/eop and last-word byte-enable.
- RX path: captures one MAC packet into a buffer and holds it until the user acknowledges; words are read back by address.

Parameters:
- TX_DEPTH, 64, TX buffer depth in 32-bit words (power of 2, ≥2).
- RX_DEPTH, 64, RX buffer depth in 32-bit words (power of 2, ≥2).
- CNT_W, 16, width of statistics counters (used only with the optional feature).
- Derived: TAW = $clog2(TX_DEPTH), RAW = $clog2(RX_DEPTH).

Ports:
- clk_user  in  1  user clock
- reset_n  in  1  asynchronous active-low reset
- cpu_init_end  in  1  MAC configured; no rd/wr is asserted while low
- rx_mac_ra  in  1  MAC has RX data available
- rx_mac_rd  out  1  read request to MAC
- rx_mac_data  in  32  RX word, big endian
- rx_mac_be  in  2  valid bytes in eop word (0 = 4 bytes, 1..3 = 1..3 bytes)
- rx_mac_pa  in  1  RX word valid this cycle
- rx_mac_sop  in  1  first word of packet
- rx_mac_eop  in  1  last word of packet
- tx_mac_wa  in  1  MAC can accept a word
- tx_mac_wr  out  1  TX word write strobe
- tx_mac_data  out  32  TX word
- tx_mac_be  out  2  valid bytes in eop word (same encoding as rx_mac_be)
- tx_mac_sop  out  1  first TX word
- tx_mac_eop  out  1  last TX word
- tx_ld_wr  in  1  user writes one packet word
- tx_ld_data  in  32  packet word
- tx_ld_be  in  2  byte count of the last word; sampled with tx_ld_last
- tx_ld_last  in  1  this word ends the packet
- tx_ld_rdy  out  1  load port can accept a word
- tx_done  out  1  one-cycle pulse after the eop word is transferred
- rx_pkt_vld  out  1  a complete packet is held
- rx_pkt_words  out  RAW+1  stored word count
- rx_pkt_be  out  2  be of the eop word
- rx_pkt_ovf  out  1  packet truncated to RX_DEPTH words
- rx_rd_addr  in  RAW  buffer read address
- rx_rd_data  out  32  registered read data, 1-cycle latency
- rx_pkt_ack  in  1  release the held packet

Behaviour:
- Reset (async, reset_n=0): both FSMs go to idle/load state; all pointers and counters = 0.
- Output reset values: every output = 0 except tx_ld_rdy = 1. Buffer contents are not reset.
- Reset mid-packet abandons the packet with no eop emitted.
- TX FSM: TX_LOAD -> TX_SEND -> TX_LOAD.
  - TX_LOAD: tx_ld_rdy = 1. Each tx_ld_wr writes buf[wptr], wptr++.
  - A write with tx_ld_last latches len = wptr+1 and be, then goes to TX_SEND.
  - A write at wptr = TX_DEPTH-1 is forced last; latched be = tx_ld_be if tx_ld_last else 0.
  - tx_ld_wr while tx_ld_rdy = 0 is ignored.
  - TX_SEND: tx_ld_rdy = 0. Combinational: tx_mac_wr = tx_mac_wa & cpu_init_end; tx_mac_data = buf[rptr].
  - tx_mac_sop = (rptr == 0); tx_mac_eop = (rptr == len-1); tx_mac_be = latched be when eop, else 0.
  - sop/eop/data/be are valid whenever in TX_SEND; they are qualified by wr.
  - Each cycle with tx_mac_wr: rptr++. A wr on eop resets both pointers, pulses tx_done next cycle, returns to TX_LOAD.
  - Single-word packet: sop = eop = 1 on the same word.
  - While wa = 0 the outputs hold, no advance.
- RX FSM: RX_IDLE -> RX_WORK -> RX_HOLD -> RX_IDLE.
  - rx_mac_rd = rx_mac_ra & cpu_init_end & (state != RX_HOLD) & ~(rx_mac_pa & rx_mac_eop).
  - RX_IDLE: pa & sop writes word 0, wptr = 1, clears ovf, goes to RX_WORK. pa without sop is discarded.
  - RX_WORK: pa writes buf[wptr], wptr++ while wptr < RX_DEPTH; beyond that the word is dropped and ovf is set.
  - pa & sop in RX_WORK restarts the packet at word 0 and clears ovf.
  - pa & eop (including sop & eop in RX_IDLE): latch rx_pkt_be, rx_pkt_words = stored count (≤ RX_DEPTH), go to RX_HOLD.
  - RX_HOLD: rx_pkt_vld = 1. rx_rd_data <= buf[rx_rd_addr] every cycle in every state.
  - rx_pkt_ack in RX_HOLD returns to RX_IDLE and clears vld next cycle. ack in any other state is ignored.
  - RX and TX operate fully concurrently.

Optional Feature:
- Macro: UIF_STATS_EN.
- Defined: adds outputs tx_pkt_cnt[CNT_W] and rx_pkt_cnt[CNT_W] plus rx_ovf_cnt[CNT_W].
  - Counters increment on tx_done, on entry to RX_HOLD, and on entry to RX_HOLD with ovf set, respectively.
  - Counters wrap at 2^CNT_W and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load 3 words 0x11111111, 0x22222222, 0x33333333 (last, be=2); wa = 1 -> wr on 3 consecutive cycles; sop on word 1, eop + be=2 on word 3; tx_done pulses once; tx_ld_rdy returns to 1.
- Same packet with wa toggled 1,0,0,1,1 -> data holds during wa = 0; exactly 3 wr; no word repeated or skipped.
- MAC delivers a 4-word RX packet (sop…eop, be=0) -> rx_pkt_vld = 1, words = 4, ovf = 0; rx_rd_addr = 2 returns word 3 one cycle later; rx_mac_rd stays 0 until rx_pkt_ack.
- RX_DEPTH = 4 with a 6-word packet -> words = 4, ovf = 1, stored words are the first four; a single-word sop&eop packet after ack gives words = 1.
- cpu_init_end = 0 with a loaded TX packet and rx_mac_ra = 1 -> no wr, no rd; raise cpu_init_end -> transfer starts; reset_n pulsed mid-TX -> outputs 0, tx_ld_rdy = 1, next packet starts with sop.
- With UIF_STATS_EN: 2 TX packets and 3 RX packets (one overflowing) -> tx_pkt_cnt = 2, rx_pkt_cnt = 3, rx_ovf_cnt = 1.
